// File: rtl/spu_rsp_retire_pkg.sv
// Shared NOU response widths and the packed response record carried through the retire FIFO.
// Width macros fall back to local defaults when the shared NOU defines are not already loaded.
`ifndef NOU_SID_WIDTH
`define NOU_SID_WIDTH 8
`endif
`ifndef NOU_RSP_TYPE_ID_WIDTH
`define NOU_RSP_TYPE_ID_WIDTH 4
`endif
`ifndef NOU_PKT_ID_WIDTH
`define NOU_PKT_ID_WIDTH 8
`endif
`ifndef NOU_ERR_CODE_WIDTH
`define NOU_ERR_CODE_WIDTH 8
`endif

package spu_rsp_retire_pkg;
    localparam int SID_W   = `NOU_SID_WIDTH;
    localparam int RTYPE_W = `NOU_RSP_TYPE_ID_WIDTH;
    localparam int PKT_W   = `NOU_PKT_ID_WIDTH;
    localparam int ERR_W   = `NOU_ERR_CODE_WIDTH;

    typedef struct packed {
        logic [SID_W-1:0]   sid;
        logic [RTYPE_W-1:0] rtype;
        logic [PKT_W-1:0]   pkt_id;
        logic               status;
        logic [ERR_W-1:0]   err_code;
    } nou_rsp_t;
endpackage

// File: rtl/nou_sync_fifo.sv
// Single-clock FIFO with an unregistered head read and an occupancy count.
// count_next is exported so the owner can register full-ness on the same edge as the push.
module nou_sync_fifo #(
    parameter type data_t = logic [7:0],
    parameter int  DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  data_t                  wr_data,
    input  logic                   pop,
    output data_t                  rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] count_next
);
    localparam int AW = $clog2(DEPTH);

    data_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Storage is deliberately left out of reset; head data is only meaningful when count != 0.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/spu_rsp_retire.sv
// Retire collector at the tail of the SPU response register stage: FIFO capture, hold
// backpressure toward the register stage, outbound valid/ready drain, and CSR error tracking.
module spu_rsp_retire
    import spu_rsp_retire_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rsp_vld,
    input  logic [SID_W-1:0]   rsp_sid,
    input  logic [RTYPE_W-1:0] rsp_rtype,
    input  logic [PKT_W-1:0]   rsp_pkt_id,
    input  logic               rsp_status,
    input  logic [ERR_W-1:0]   rsp_err_code,
    output logic               retire_keep,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [SID_W-1:0]   out_sid,
    output logic [RTYPE_W-1:0] out_rtype,
    output logic [PKT_W-1:0]   out_pkt_id,
    output logic               out_status,
    output logic [ERR_W-1:0]   out_err_code,
    input  logic               err_clr,
    output logic [CNT_W-1:0]   err_cnt,
    output logic               err_seen,
    output logic [SID_W-1:0]   last_err_sid,
    output logic [ERR_W-1:0]   last_err_code
);
    localparam int CW = $clog2(DEPTH) + 1;

    nou_rsp_t      wr_rsp;
    nou_rsp_t      head;
    logic          acc;
    logic          pop;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    // The register stage holds its outputs under keep, so a held entry is taken once keep drops.
    assign acc    = rsp_vld & ~retire_keep;
    assign pop    = out_vld & out_rdy;
    assign wr_rsp = '{sid: rsp_sid, rtype: rsp_rtype, pkt_id: rsp_pkt_id,
                      status: rsp_status, err_code: rsp_err_code};

    nou_sync_fifo #(
        .data_t (nou_rsp_t),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (acc),
        .wr_data    (wr_rsp),
        .pop        (pop),
        .rd_data    (head),
        .count      (count),
        .count_next (count_next)
    );

    assign out_vld      = (count != '0);
    assign out_sid      = head.sid;
    assign out_rtype    = head.rtype;
    assign out_pkt_id   = head.pkt_id;
    assign out_status   = head.status;
    assign out_err_code = head.err_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) retire_keep <= 1'b0;
        else     retire_keep <= (count_next == CW'(DEPTH));
    end

    // A same-cycle clear beats the increment, but the last-error capture still happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt       <= '0;
            err_seen      <= 1'b0;
            last_err_sid  <= '0;
            last_err_code <= '0;
        end else begin
            if (err_clr) begin
                err_cnt  <= '0;
                err_seen <= 1'b0;
            end else if (acc && rsp_status) begin
                err_seen <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end
            if (acc && rsp_status) begin
                last_err_sid  <= rsp_sid;
                last_err_code <= rsp_err_code;
            end
        end
    end
endmodule

// File: tb/tb_spu_rsp_retire.sv
// Directed bench for spu_rsp_retire: scoreboard of accepted responses checked against the
// drained stream, plus a cycle model of occupancy/keep and directed error-tracking checks.
module tb_spu_rsp_retire;
    import spu_rsp_retire_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               rsp_vld = 1'b0;
    logic [SID_W-1:0]   rsp_sid = '0;
    logic [RTYPE_W-1:0] rsp_rtype = '0;
    logic [PKT_W-1:0]   rsp_pkt_id = '0;
    logic               rsp_status = 1'b0;
    logic [ERR_W-1:0]   rsp_err_code = '0;
    logic               retire_keep;
    logic               out_vld;
    logic               out_rdy = 1'b0;
    logic [SID_W-1:0]   out_sid;
    logic [RTYPE_W-1:0] out_rtype;
    logic [PKT_W-1:0]   out_pkt_id;
    logic               out_status;
    logic [ERR_W-1:0]   out_err_code;
    logic               err_clr = 1'b0;
    logic [CNT_W-1:0]   err_cnt;
    logic               err_seen;
    logic [SID_W-1:0]   last_err_sid;
    logic [ERR_W-1:0]   last_err_code;

    spu_rsp_retire #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .rsp_vld(rsp_vld), .rsp_sid(rsp_sid), .rsp_rtype(rsp_rtype),
        .rsp_pkt_id(rsp_pkt_id), .rsp_status(rsp_status), .rsp_err_code(rsp_err_code),
        .retire_keep(retire_keep), .out_vld(out_vld), .out_rdy(out_rdy), .out_sid(out_sid),
        .out_rtype(out_rtype), .out_pkt_id(out_pkt_id), .out_status(out_status),
        .out_err_code(out_err_code), .err_clr(err_clr), .err_cnt(err_cnt),
        .err_seen(err_seen), .last_err_sid(last_err_sid), .last_err_code(last_err_code)
    );

    always #5 clk = ~clk;

    int       n_chk = 0;
    int       n_pass = 0;
    int       n_pop = 0;
    bit       rnd_rdy = 1'b0;
    nou_rsp_t sb[$];
    nou_rsp_t cur_o;
    nou_rsp_t prev_o;
    bit       stall_prev = 1'b0;
    int       mdl_cnt = 0;
    bit       mdl_keep = 1'b0;

    assign cur_o = {out_sid, out_rtype, out_pkt_id, out_status, out_err_code};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic nou_rsp_t mk(input int sid, input int rt, input int pkt,
                                    input bit st, input int code);
        nou_rsp_t r;
        r.sid = SID_W'(sid); r.rtype = RTYPE_W'(rt); r.pkt_id = PKT_W'(pkt);
        r.status = st; r.err_code = ERR_W'(code);
        return r;
    endfunction

    // Occupancy/keep reference, written from the retire rules rather than the FIFO structure.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_cnt  <= 0;
            mdl_keep <= 1'b0;
        end else begin
            int nxt;
            nxt = mdl_cnt + int'(rsp_vld && !mdl_keep) - int'(mdl_cnt != 0 && out_rdy);
            mdl_cnt  <= nxt;
            mdl_keep <= (nxt == DEPTH);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            chk("out_vld", out_vld, mdl_cnt != 0);
            chk("retire_keep", retire_keep, mdl_keep);
            if (stall_prev) chk("stall_stable", cur_o, prev_o);
            if (out_vld && out_rdy) begin
                if (sb.size() == 0) chk("unexpected_out", cur_o, '1);
                else chk("out_data", cur_o, sb.pop_front());
                n_pop++;
            end
            stall_prev = out_vld && !out_rdy;
            prev_o     = cur_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_rdy) out_rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic drive(input nou_rsp_t r);
        rsp_vld = 1'b1; rsp_sid = r.sid; rsp_rtype = r.rtype;
        rsp_pkt_id = r.pkt_id; rsp_status = r.status; rsp_err_code = r.err_code;
    endtask

    task automatic wait_acc(input nou_rsp_t r);
        bit k;
        for (int i = 0; i < 200; i++) begin
            k = mdl_keep;
            step();
            if (!k) begin
                sb.push_back(r);
                return;
            end
        end
        chk("accept_timeout", 0, 1);
    endtask

    task automatic send(input nou_rsp_t r);
        drive(r);
        wait_acc(r);
        rsp_vld = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) step();
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int p0;
        #1;
        chk("rst_out_vld", out_vld, 0);
        chk("rst_keep", retire_keep, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_err_seen", err_seen, 0);
        chk("rst_last_sid", last_err_sid, 0);
        chk("rst_last_code", last_err_code, 0);
        step(); step();
        rst = 1'b0;

        // single ok response, visible for exactly one cycle
        out_rdy = 1'b1;
        send(mk(3, 1, 'h12, 0, 0));
        chk("single_vld_hi", out_vld, 1);
        chk("single_pkt", out_pkt_id, 'h12);
        step();
        chk("single_vld_lo", out_vld, 0);
        chk("single_err_cnt", err_cnt, 0);

        // fill to full with the sink stalled, fifth response held
        out_rdy = 1'b0;
        p0 = n_pop;
        for (int i = 1; i <= 4; i++) send(mk(i, i, i, 0, 0));
        chk("full_keep", retire_keep, 1);
        drive(mk(5, 5, 5, 0, 0));
        step(); step(); step();
        chk("held_keep", retire_keep, 1);
        chk("held_head", out_pkt_id, 1);
        out_rdy = 1'b1;
        wait_acc(mk(5, 5, 5, 0, 0));
        rsp_vld = 1'b0;
        drain();
        step();
        chk("full_pop_count", n_pop - p0, 5);

        // random stalls over 20 ids
        p0 = n_pop;
        rnd_rdy = 1'b1;
        for (int i = 0; i < 20; i++) send(mk(i + 16, i, 'h40 + i, 0, 0));
        rnd_rdy = 1'b0;
        out_rdy = 1'b1;
        drain();
        step();
        chk("stall_pop_count", n_pop - p0, 20);

        // error tracking and saturation of the 2-bit counter
        for (int i = 0; i < 3; i++) begin
            send(mk(i + 1, 2, 'h80 + i, 1, 5 + i));
            chk("err_cnt_inc", err_cnt, i + 1);
        end
        chk("err_seen", err_seen, 1);
        chk("last_err_sid", last_err_sid, 3);
        chk("last_err_code", last_err_code, 7);
        send(mk(5, 2, 'h83, 1, 8));
        send(mk(6, 2, 'h84, 1, 9));
        chk("err_cnt_sat", err_cnt, 3);
        chk("last_err_sid_sat", last_err_sid, 6);
        send(mk(7, 2, 'h85, 0, 'hee));
        chk("ok_no_last_update", last_err_code, 9);

        // clear coincident with an error
        err_clr = 1'b1;
        send(mk(9, 3, 'h90, 1, 'ha));
        err_clr = 1'b0;
        chk("clr_err_cnt", err_cnt, 0);
        chk("clr_err_seen", err_seen, 0);
        chk("clr_last_sid", last_err_sid, 9);
        chk("clr_last_code", last_err_code, 'ha);
        drain();

        // reset with entries queued
        out_rdy = 1'b0;
        send(mk(4, 1, 'ha0, 1, 1));
        send(mk(4, 1, 'ha1, 0, 0));
        send(mk(4, 1, 'ha2, 0, 0));
        chk("pre_rst_keep", retire_keep, 0);
        chk("pre_rst_vld", out_vld, 1);
        chk("pre_rst_err_cnt", err_cnt, 1);
        sb.delete();
        rst = 1'b1;
        #1;
        chk("mid_rst_vld", out_vld, 0);
        step(); step();
        rst = 1'b0;
        chk("post_rst_keep", retire_keep, 0);
        chk("post_rst_err_cnt", err_cnt, 0);
        chk("post_rst_err_seen", err_seen, 0);
        chk("post_rst_last_sid", last_err_sid, 0);
        out_rdy = 1'b1;
        p0 = n_pop;
        send(mk(2, 2, 'hb0, 0, 0));
        drain();
        step();
        chk("post_rst_pop", n_pop - p0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/spu_rsp_retire.md
# spu_rsp_retire

Response retire collector for the NOU SPU: it is the consuming end of the `spu_spur` response register stage. It captures each registered response (vld/sid/rtype/pkt_id/status/err_code) into a small FIFO. It drives `retire_keep` back to the register stage as hold-backpressure, and drains entries onto an outbound valid/ready retire channel. It also keeps a saturating error counter and a sticky error flag for CSR readout.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 16: error counter width.
- `clk` in 1: sole clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rsp_vld` in 1: response valid from the register stage (`vld_q`).
- `rsp_sid` in `NOU_SID_WIDTH`: stream id.
- `rsp_rtype` in `NOU_RSP_TYPE_ID_WIDTH`: response type.
- `rsp_pkt_id` in `NOU_PKT_ID_WIDTH`: packet id.
- `rsp_status` in 1: 1 = error, 0 = ok.
- `rsp_err_code` in `NOU_ERR_CODE_WIDTH`: error code; meaningful only when `rsp_status`=1.
- `retire_keep` out 1: hold request to the register stage; registered.
- `out_vld` out 1: outbound entry valid.
- `out_rdy` in 1: outbound sink ready.
- `out_sid`, `out_rtype`, `out_pkt_id`, `out_status`, `out_err_code` out (same widths as inputs): head-of-FIFO fields.
- `err_clr` in 1: clears `err_cnt` and `err_seen`.
- `err_cnt` out `CNT_W`: saturating count of accepted responses with status=1.
- `err_seen` out 1: sticky, set on any accepted error response.
- `last_err_sid`, `last_err_code` out: sid and err_code of the most recent accepted error.

## Operation
- Accept: `acc = rsp_vld & ~retire_keep`.
  - The register stage holds its outputs while `retire_keep`=1.
  - A held entry is therefore taken exactly once, in the first cycle `retire_keep`=0.
- Push on `acc`: write all five fields at `wr_ptr` and increment `wr_ptr` modulo DEPTH.
- Pop on `out_vld & out_rdy`: increment `rd_ptr`.
- `count` is `$clog2(DEPTH)+1` bits:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- `retire_keep` register next value: `count_next == DEPTH`. Push therefore never occurs when full.
- `out_vld = (count != 0)`. Outbound fields come straight from FIFO storage at `rd_ptr`, with no output register.
  - While `out_vld`=1 and `out_rdy`=0, all `out_*` hold stable.
- Error tracking on `acc & rsp_status`:
  - `err_seen` ← 1.
  - `err_cnt` ← `err_cnt+1`, saturating at all-ones.
  - `last_err_sid` / `last_err_code` ← input fields.
- `err_clr` priority:
  - `err_clr` wins over a same-cycle error: counter = 0, flag = 0, `last_err_*` still updated.
  - `err_clr` does not touch the FIFO.
- Responses with `rsp_vld`=0 are ignored. Fields on an invalid cycle never enter the FIFO or the error logic.

## Timing
- Reset values (async assert, sync-safe release):
  - `retire_keep`=0, `out_vld`=0 (count=0), pointers=0, `err_cnt`=0, `err_seen`=0, `last_err_*`=0.
  - FIFO storage is not reset; `out_*` data are don't-care while `out_vld`=0.
- Latency: a response accepted at edge N is visible on `out_vld`/`out_*` after edge N (one cycle, FIFO write then read).
- Throughput: one accept and one pop per cycle. The steady state with `out_rdy`=1 never raises `retire_keep`.
- Full boundary:
  - The push that makes count=DEPTH asserts `retire_keep` on the same edge.
  - The first pop from full drops `retire_keep` after that edge.
  - The held entry is accepted in the following cycle. This gives one bubble, which is intentional.
- Push and pop when count=DEPTH−1: count is unchanged and `retire_keep` stays 0.
- Pointer wrap at DEPTH−1 → 0 is silent. Ordering is strictly FIFO.
- Reset mid-operation flushes all entries; in-flight responses are lost by design.

## Structure
- Width macros `NOU_SID_WIDTH`, `NOU_RSP_TYPE_ID_WIDTH`, `NOU_PKT_ID_WIDTH`, `NOU_ERR_CODE_WIDTH` are reused from the shared NOU defines.
- Add a packed `nou_rsp_t` struct (sid, rtype, pkt_id, status, err_code) to the shared NOU package; FIFO storage is an array of `nou_rsp_t`.
- One sub-module, `nou_sync_fifo` (parameterised width/depth, count output). The top level adds the keep logic and error tracking.

## Test plan
- Single ok response (sid=3, pkt_id=0x12, status=0), `out_rdy`=1:
  - `out_vld` for exactly 1 cycle, one cycle later, with matching fields.
  - `err_cnt`=0 and `retire_keep` never asserted.
- `out_rdy`=0 with 5 back-to-back responses, pkt_id 1..5, DEPTH=4:
  - `retire_keep`=1 after the 4th accept.
  - pkt 5 held.
  - Raising `out_rdy` drains 1,2,3,4,5 in order with no loss or duplicate.
- Stall-stability: `out_rdy` toggled randomly while feeding 20 ids → output sequence equals input sequence and `out_*` are stable during stall.
- Errors: 3 responses with status=1 (err_code 0x5, 0x6, 0x7, sid 1, 2, 3) → `err_cnt`=3, `err_seen`=1, `last_err_sid`=3, `last_err_code`=0x7.
- Saturation and clear:
  - With `CNT_W`=2, 5 errors → `err_cnt`=3.
  - `err_clr` coincident with an error (sid=9) → `err_cnt`=0, `err_seen`=0, `last_err_sid`=9.
- Reset with 3 entries queued and `retire_keep`=0 → `out_vld`=0, `retire_keep`=0, counters 0; the next response passes normally.
